// File: rtl/jelly_shift_fifo_pkg.sv
// Shared constants and helpers for the jelly shift-FIFO controller.
// Optional output register stage is enabled by JELLY_SHIFT_FIFO_OUTREG_EN.
package jelly_shift_fifo_pkg;

    // Counters must hold 0..NUM and, with the output stage, NUM+1.
    function automatic int jelly_shift_fifo_cnt_width(input int sel_width);
        return sel_width + 1;
    endfunction

    function automatic logic [31:0] jelly_shift_fifo_sel_from_count(input logic [31:0] cnt);
        logic [31:0] sel;
        if (cnt == 32'd0) begin
            sel = 32'd0;
        end else begin
            sel = cnt - 32'd1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/jelly_shift_fifo_outreg.sv
// Registered output stage behind the shifter tap; only built when
// JELLY_SHIFT_FIFO_OUTREG_EN is defined.
`ifdef JELLY_SHIFT_FIFO_OUTREG_EN
module jelly_shift_fifo_outreg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cke,
    input  logic                  i_avail,
    input  logic                  i_rd,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_load,
    output logic                  o_valid,
    output logic                  o_valid_next,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_valid_next;

    // Refill from the oldest shifter entry whenever the stage is free or draining.
    assign o_load = cke & i_avail & (~r_valid | i_rd);

    // Stage occupancy for the next cycle
    always_comb begin
        w_valid_next = r_valid;
        if (o_load) begin
            w_valid_next = 1'b1;
        end else if (i_rd) begin
            w_valid_next = 1'b0;
        end else begin
            w_valid_next = r_valid;
        end
    end

    // Stage flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (cke) begin
            r_valid <= w_valid_next;
            if (o_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_valid_next = w_valid_next;
    assign o_data       = r_data;

endmodule
`endif

// File: rtl/jelly_shift_fifo_ctl.sv
// Valid/ready controller running an external variable-tap shifter as an SRL FIFO.
// Define JELLY_SHIFT_FIFO_OUTREG_EN to add a registered output stage (capacity NUM+1).
module jelly_shift_fifo_ctl
    import jelly_shift_fifo_pkg::*;
#(
    parameter int SEL_WIDTH  = 5,
    parameter int NUM        = (1 << SEL_WIDTH),
    parameter int DATA_WIDTH = 8
) (
    input  logic                  reset_n,
    input  logic                  clk,
    input  logic                  cke,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [SEL_WIDTH:0]    data_count,
    output logic                  shift_cke,
    output logic [SEL_WIDTH-1:0]  shift_sel,
    output logic [DATA_WIDTH-1:0] shift_in_data,
    input  logic [DATA_WIDTH-1:0] shift_out_data
);

    localparam int CNT_WIDTH = jelly_shift_fifo_cnt_width(SEL_WIDTH);
`ifdef JELLY_SHIFT_FIFO_OUTREG_EN
    localparam int CAPACITY = NUM + 1;
`else
    localparam int CAPACITY = NUM;
`endif
    localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(CAPACITY);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_sc;
    logic [CNT_WIDTH-1:0] r_dc;
    logic [SEL_WIDTH-1:0] r_sel;
    logic                 r_s_ready;
    logic [CNT_WIDTH-1:0] w_sc_next;
    logic [CNT_WIDTH-1:0] w_total_next;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_m_valid;
    logic                 w_shift_out;
    logic                 w_stage_full_next;

    assign w_wr = s_valid & r_s_ready & cke;
    assign w_rd = w_m_valid & m_ready & cke;

`ifdef JELLY_SHIFT_FIFO_OUTREG_EN
    jelly_shift_fifo_outreg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outreg (
        .clk          (clk),
        .reset_n      (reset_n),
        .cke          (cke),
        .i_avail      (r_sc != '0),
        .i_rd         (w_rd),
        .i_data       (shift_out_data),
        .o_load       (w_shift_out),
        .o_valid      (w_m_valid),
        .o_valid_next (w_stage_full_next),
        .o_data       (m_data)
    );
`else
    logic r_m_valid;

    // The tap itself is the output, so valid simply tracks a non-empty shifter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_valid <= 1'b0;
        end else if (cke) begin
            r_m_valid <= (w_sc_next != '0);
        end
    end

    assign w_m_valid         = r_m_valid;
    assign w_shift_out       = w_rd;
    assign w_stage_full_next = 1'b0;
    assign m_data            = shift_out_data;
`endif

    // Next shifter occupancy and total held count
    always_comb begin
        w_sc_next = r_sc;
        if (w_wr && !w_shift_out) begin
            w_sc_next = r_sc + ONE;
        end else if (!w_wr && w_shift_out) begin
            w_sc_next = r_sc - ONE;
        end else begin
            w_sc_next = r_sc;
        end
        w_total_next = w_sc_next + CNT_WIDTH'(w_stage_full_next);
    end

    // Sel moves with sc so it always addresses the oldest entry; no write-through at full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sc      <= '0;
            r_dc      <= '0;
            r_sel     <= '0;
            r_s_ready <= 1'b0;
        end else if (cke) begin
            r_sc      <= w_sc_next;
            r_dc      <= w_total_next;
            r_sel     <= SEL_WIDTH'(jelly_shift_fifo_sel_from_count(32'(w_sc_next)));
            r_s_ready <= (w_total_next < CAP);
        end
    end

    assign s_ready       = r_s_ready;
    assign m_valid       = w_m_valid;
    assign data_count    = r_dc;
    assign shift_cke     = w_wr;
    assign shift_sel     = r_sel;
    assign shift_in_data = s_data;

endmodule

// File: tb/tb_jelly_shift_fifo_ctl.sv
// Self-checking bench for jelly_shift_fifo_ctl with a behavioural shifter attached;
// follows JELLY_SHIFT_FIFO_OUTREG_EN for capacity and latency.
module tb_jelly_shift_fifo_ctl;

    localparam int SEL_WIDTH  = 5;
    localparam int NUM        = 32;
    localparam int DATA_WIDTH = 8;
`ifdef JELLY_SHIFT_FIFO_OUTREG_EN
    localparam int CAP = NUM + 1;
    localparam int LAT = 2;
`else
    localparam int CAP = NUM;
    localparam int LAT = 1;
`endif

    logic                  reset_n;
    logic                  clk;
    logic                  cke;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [SEL_WIDTH:0]    data_count;
    logic                  shift_cke;
    logic [SEL_WIDTH-1:0]  shift_sel;
    logic [DATA_WIDTH-1:0] shift_in_data;
    logic [DATA_WIDTH-1:0] shift_out_data;

    jelly_shift_fifo_ctl #(
        .SEL_WIDTH  (SEL_WIDTH),
        .NUM        (NUM),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .reset_n        (reset_n),
        .clk            (clk),
        .cke            (cke),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .data_count     (data_count),
        .shift_cke      (shift_cke),
        .shift_sel      (shift_sel),
        .shift_in_data  (shift_in_data),
        .shift_out_data (shift_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural variable-tap shifter: newest at tap 0.
    logic [DATA_WIDTH-1:0] shreg [NUM];
    always_ff @(posedge clk) begin
        if (shift_cke) begin
            for (int i = NUM - 1; i > 0; i--) shreg[i] <= shreg[i-1];
            shreg[0] <= shift_in_data;
        end
    end
    assign shift_out_data = shreg[shift_sel];

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_WIDTH-1:0] sb [$];

    // Reference state
    int   m_sc  = 0;
    int   m_dc  = 0;
    logic m_vld = 1'b0;
    logic m_rdy = 1'b0;
`ifdef JELLY_SHIFT_FIFO_OUTREG_EN
    logic m_v   = 1'b0;
`endif

    typedef struct {
        logic                  sv;
        logic [DATA_WIDTH-1:0] sd;
        logic                  mr;
        logic                  ck;
        int                    exp_dc;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sc = 0; m_dc = 0; m_vld = 1'b0; m_rdy = 1'b0;
`ifdef JELLY_SHIFT_FIFO_OUTREG_EN
        m_v = 1'b0;
`endif
        sb.delete();
    endtask

    task automatic model_edge(input logic wr, input logic rd, input logic ck);
`ifdef JELLY_SHIFT_FIFO_OUTREG_EN
        logic ld;
`endif
        if (ck) begin
`ifdef JELLY_SHIFT_FIFO_OUTREG_EN
            ld    = (m_sc > 0) && (!m_v || rd);
            m_sc  = m_sc + int'(wr) - int'(ld);
            m_v   = ld ? 1'b1 : (rd ? 1'b0 : m_v);
            m_vld = m_v;
            m_dc  = m_sc + int'(m_v);
`else
            m_sc  = m_sc + int'(wr) - int'(rd);
            m_vld = (m_sc > 0);
            m_dc  = m_sc;
`endif
            m_rdy = (m_dc < CAP);
        end
    endtask

    // One clock: drive, check combinational side, advance, check registered state.
    task automatic cycle(input logic sv, input logic [DATA_WIDTH-1:0] sd, input logic mr, input logic ck);
        logic wr;
        logic rd;
        s_valid = sv; s_data = sd; m_ready = mr; cke = ck;
        wr = ck & sv & m_rdy;
        rd = ck & m_vld & mr;
        #1;
        chk("shift_cke", int'(shift_cke), int'(wr));
        chk("shift_in_data", int'(shift_in_data), int'(sd));
        if (m_vld) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                chk("m_data", int'(m_data), int'(sb[0]));
                if (rd) void'(sb.pop_front());
            end
        end
        if (wr) sb.push_back(sd);
        @(posedge clk);
        model_edge(wr, rd, ck);
        #1;
        chk("s_ready", int'(s_ready), int'(m_rdy));
        chk("m_valid", int'(m_valid), int'(m_vld));
        chk("data_count", int'(data_count), m_dc);
        chk("shift_sel", int'(shift_sel), (m_sc > 0) ? m_sc - 1 : 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 2};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 3};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 3};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 3};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 2};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 0};

        reset_n = 1'b0; cke = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_data_count", int'(data_count), 0);
        chk("rst_shift_sel", int'(shift_sel), 0);
        chk("rst_shift_cke", int'(shift_cke), 0);
        reset_n = 1'b1;
        model_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s_ready_rise", int'(s_ready), 1);

        // Three writes held under backpressure, then popped in order
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].sv, tbl[i].sd, tbl[i].mr, tbl[i].ck);
            chk($sformatf("tbl%0d_dc", i), int'(data_count), tbl[i].exp_dc);
            if (i == 2) chk("tbl_sel_after3", int'(shift_sel), (LAT == 1) ? 2 : 1);
        end
        chk("tbl_m_valid_end", int'(m_valid), 0);

        // Write-to-valid latency on an empty FIFO
        cycle(1'b1, 8'hA5, 1'b0, 1'b1);
        chk("lat_edge1", int'(m_valid), (LAT == 1) ? 1 : 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("lat_edge2", int'(m_valid), 1);
        drain(4);

        // Fill to capacity, refuse extra write, one pop reopens s_ready
        for (int i = 0; i < CAP; i++) cycle(1'b1, 8'(i * 7 + 3), 1'b0, 1'b1);
        chk("full_s_ready", int'(s_ready), 0);
        chk("full_dc", int'(data_count), CAP);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("full_extra_dc", int'(data_count), CAP);
        cycle(1'b1, 8'hEF, 1'b1, 1'b1);
        chk("pop_s_ready", int'(s_ready), 1);
        drain(CAP + 3);
        chk("drained_dc", int'(data_count), 0);

        // Steady stream at depth 4, with a cke stall in the middle
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b1);
            if (i == 50) begin
                for (int k = 0; k < 5; k++) cycle(1'b1, 8'hC3, 1'b1, 1'b0);
                chk("stall_dc", int'(data_count), 4);
            end
        end
        chk("stream_dc", int'(data_count), 4);
        chk("stream_sel", int'(shift_sel), (LAT == 1) ? 3 : 2);
        drain(8);

        // Asynchronous reset with 10 entries held
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b1);
        chk("pre_rst_dc", int'(data_count), 10);
        reset_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk("arst_dc", int'(data_count), 0);
        chk("arst_m_valid", int'(m_valid), 0);
        chk("arst_s_ready", int'(s_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b1);
        drain(8);

        // Random traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) != 0));
        end
        drain(CAP + 4);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_dc", int'(data_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
